// File: rtl/sram_rw_port_bridge.sv
// sram_rw_port_bridge: valid/ready front end for port 0 (1RW) of a 32x256
// byte-masked SRAM macro. Requests drive the macro pins combinationally.
// Read data is either passed straight through from dout0 or captured into
// hold_q when the consumer stalls. Writes are posted and have no response.
// Optional feature macro: SRAM_BRIDGE_STATS_EN adds saturating access counters.
module sram_rw_port_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_WMASKS-1:0] req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
`ifdef SRAM_BRIDGE_STATS_EN
    ,
    input  logic                  stat_clear,
    output logic [31:0]           stat_reads,
    output logic [31:0]           stat_writes
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,   // no read outstanding
        PEND  = 2'd1,   // macro is driving the read word this cycle
        HOLD  = 2'd2    // read word parked in hold_q
    } rsp_state_t;

    rsp_state_t            state;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  accept;
    logic                  accept_rd;
    logic                  accept_wr;
    logic                  unused_addr_lsbs;

    // Byte offset bits never reach the macro.
    assign unused_addr_lsbs = ^req_addr[1:0];

    // One read may be live or held at a time; a write can slip in while HOLD drains.
    assign req_ready = ~reset & ((state == EMPTY) |
                                 ((state == PEND) & rsp_ready) |
                                 ((state == HOLD) & rsp_ready & req_write));

    assign accept    = req_valid & req_ready;
    assign accept_rd = accept & ~req_write;
    assign accept_wr = accept & req_write & (|req_wstrb);

    // Macro pins follow the request directly; an empty-strobe write never selects the macro.
    assign sram_csb0   = ~(accept & (~req_write | (|req_wstrb)));
    assign sram_web0   = ~req_write;
    assign sram_wmask0 = req_wstrb;
    assign sram_addr0  = req_addr[ADDR_WIDTH+1:2];
    assign sram_din0   = req_wdata;

    // Response is suppressed during reset so a read in flight is dropped cleanly.
    assign rsp_valid = ~reset & (state != EMPTY);
    assign rsp_rdata = (state == PEND) ? sram_dout0 : hold_q;

    // Response FSM: capture dout0 into hold_q only when the consumer stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= EMPTY;
            hold_q <= '0;
        end else begin
            case (state)
                EMPTY: if (accept_rd) state <= PEND;
                PEND: begin
                    if (rsp_ready) begin
                        state <= accept_rd ? PEND : EMPTY;
                    end else begin
                        hold_q <= sram_dout0;
                        state  <= HOLD;
                    end
                end
                HOLD: if (rsp_ready) state <= EMPTY;
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef SRAM_BRIDGE_STATS_EN
    // Saturating access counters; clear has priority over an increment.
    always_ff @(posedge clock) begin
        if (reset || stat_clear) begin
            stat_reads  <= '0;
            stat_writes <= '0;
        end else begin
            if (accept_rd && (stat_reads != 32'hFFFF_FFFF))
                stat_reads <= stat_reads + 32'd1;
            if (accept_wr && (stat_writes != 32'hFFFF_FFFF))
                stat_writes <= stat_writes + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_rw_port_bridge.sv
// Directed bench for sram_rw_port_bridge with a behavioural SRAM macro model,
// a reference memory and an in-order read-data scoreboard.
module tb_sram_rw_port_bridge;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NM = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_write;
    logic [AW+1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [NM-1:0] req_wstrb;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          sram_csb0, sram_web0;
    logic [NM-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0;
`ifdef SRAM_BRIDGE_STATS_EN
    logic          stat_clear;
    logic [31:0]   stat_reads, stat_writes;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] mac_mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_q [$];
    int            rsp_cyc [$];

    // last request's observations
    logic [AW-1:0] last_addr;
    logic          last_csb;
    logic          last_web;
    int            last_wait;

    sram_rw_port_bridge #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(NM)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
`ifdef SRAM_BRIDGE_STATS_EN
        , .stat_clear(stat_clear), .stat_reads(stat_reads), .stat_writes(stat_writes)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Macro model: dout0 is valid only in the cycle after a read, X otherwise.
    always @(posedge clock) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                for (int b = 0; b < NM; b++)
                    if (sram_wmask0[b]) mac_mem[sram_addr0][8*b +: 8] <= sram_din0[8*b +: 8];
                sram_dout0 <= 'x;
            end else begin
                sram_dout0 <= mac_mem[sram_addr0];
            end
        end else begin
            sram_dout0 <= 'x;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every handshaken response pops the oldest expected word.
    always @(negedge clock) begin
        if (!reset && rsp_valid && rsp_ready) begin
            rsp_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                check("rsp_rdata", rsp_rdata, exp_q.pop_front());
            end
        end
    end

    // Present one request, wait (bounded) for req_ready, let it be accepted.
    task automatic do_req(input logic wr, input logic [AW+1:0] a,
                          input logic [DW-1:0] d, input logic [NM-1:0] s);
        int n = 0;
        logic [AW-1:0] w;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
        @(negedge clock);
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
        last_wait = n;
        last_addr = sram_addr0;
        last_csb  = sram_csb0;
        last_web  = sram_web0;
        w = a[AW+1:2];
        if (!wr) begin
            exp_q.push_back(ref_mem[w]);
        end else begin
            for (int b = 0; b < NM; b++)
                if (s[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
        end
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < (1<<AW); i++) begin
            ref_mem[i] = '0;
            mac_mem[i] = '0;
        end
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b1;
`ifdef SRAM_BRIDGE_STATS_EN
        stat_clear = 1'b0;
`endif
        idle(3);
        @(negedge clock);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_csb0",      {31'd0, sram_csb0}, 32'd1);
        @(posedge clock); #1;
        reset = 1'b0;

        // write then read same word; check address mapping and latency
        do_req(1'b1, 10'h010, 32'hDEADBEEF, 4'hF);
        check("wr_addr0", {24'd0, last_addr}, 32'h04);
        check("wr_csb0",  {31'd0, last_csb},  32'd0);
        check("wr_web0",  {31'd0, last_web},  32'd0);
        do_req(1'b0, 10'h010, '0, 4'h0);
        check("rd_addr0", {24'd0, last_addr}, 32'h04);
        check("rd_web0",  {31'd0, last_web},  32'd1);
        @(negedge clock);
        check("rd_latency_valid", {31'd0, rsp_valid}, 32'd1);
        idle(2);

        // partial write merge
        do_req(1'b1, 10'h040, 32'h11223344, 4'hF);
        do_req(1'b1, 10'h040, 32'hAABBCCDD, 4'b0101);
        do_req(1'b0, 10'h040, '0, 4'h0);
        idle(2);
        check("merge_ref", ref_mem[8'h10], 32'h11BB33DD);

        // backpressure: response must hold steady while rsp_ready is low
        rsp_ready = 1'b0;
        do_req(1'b0, 10'h010, '0, 4'h0);
        req_valid = 1'b1; req_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rdata", rsp_rdata, 32'hDEADBEEF);
            check("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        @(posedge clock); #1;
        rsp_ready = 1'b1;
        idle(2);

        // four back-to-back reads
        for (int i = 0; i < 4; i++)
            do_req(1'b1, 10'h080 + 10'(4*i), 32'hC0DE0000 + 32'(i), 4'hF);
        rsp_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 10'h080 + 10'(4*i), '0, 4'h0);
            check("b2b_ready", 32'(last_wait), 32'd0);
        end
        idle(3);
        check("b2b_count", 32'(rsp_cyc.size()), 32'd4);
        for (int i = 0; i + 1 < rsp_cyc.size(); i++)
            check("b2b_consec", 32'(rsp_cyc[i+1] - rsp_cyc[i]), 32'd1);

        // empty-strobe write is a no-op
        do_req(1'b1, 10'h080, 32'hFFFFFFFF, 4'h0);
        check("nop_csb0",  {31'd0, last_csb}, 32'd1);
        check("nop_ready", 32'(last_wait), 32'd0);
        do_req(1'b0, 10'h080, '0, 4'h0);
        idle(2);

        // reset the cycle after a read accept drops the response
        do_req(1'b0, 10'h040, '0, 4'h0);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_mid_csb0",  {31'd0, sram_csb0}, 32'd1);
        exp_q.delete();
        idle(2);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clock); #1;

        do_req(1'b1, 10'h100, 32'h01020304, 4'hF);
        do_req(1'b1, 10'h104, 32'h05060708, 4'h3);
        do_req(1'b0, 10'h100, '0, 4'h0);
        do_req(1'b0, 10'h104, '0, 4'h0);
        do_req(1'b0, 10'h010, '0, 4'h0);
        idle(2);
`ifdef SRAM_BRIDGE_STATS_EN
        check("stat_writes", stat_writes, 32'd2);
        check("stat_reads",  stat_reads,  32'd3);
        stat_clear = 1'b1;
        idle(1);
        stat_clear = 1'b0;
        @(negedge clock);
        check("stat_clr_w", stat_writes, 32'd0);
        check("stat_clr_r", stat_reads,  32'd0);
`endif

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
